// File: rtl/key_rotate_sched_if.sv
// key_rotate_sched_if: handshake/data bundle for the DES key-schedule rotator.
//   start/mode/cIn/dIn : schedule request (producer -> rotator)
//   busy               : schedule in progress
//   outValid/outReady  : per-round valid/ready handshake
//   cOut/dOut/roundIdx : current rotated halves and round position (1..ROUNDS)
//   last               : marks the final round
interface key_rotate_sched_if #(
  parameter int HALF_W = 28,
  parameter int RW     = 5
);
  logic              start;
  logic              mode;
  logic [HALF_W-1:0] cIn;
  logic [HALF_W-1:0] dIn;
  logic              busy;
  logic              outValid;
  logic              outReady;
  logic [HALF_W-1:0] cOut;
  logic [HALF_W-1:0] dOut;
  logic [RW-1:0]     roundIdx;
  logic              last;

  modport master (
    output start, mode, cIn, dIn, outReady,
    input  busy, outValid, cOut, dOut, roundIdx, last
  );

  modport slave (
    input  start, mode, cIn, dIn, outReady,
    output busy, outValid, cOut, dOut, roundIdx, last
  );
endinterface

// File: rtl/key_rotate_sched.sv
// key_rotate_sched: sequential DES key-schedule rotator.
// Loads the post-PC-1 halves C0/D0 on start and emits one rotated (Cn, Dn)
// pair per round over a valid/ready handshake. Encrypt rotates left by
// 1 + SHIFT_MASK[r-1] per round r; decrypt emits the same halves in reverse
// round order by pre-rotating the seed by the full-schedule total and then
// rotating right.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : key_rotate_sched_if slave (request, handshake, outputs)
module key_rotate_sched #(
  parameter int              HALF_W     = 28,
  parameter int              ROUNDS     = 16,
  parameter logic [ROUNDS-1:0] SHIFT_MASK = 16'h7EFC,
  parameter int              RW         = $clog2(ROUNDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  key_rotate_sched_if.slave bus
);

  if (HALF_W < 3 || ROUNDS < 1) begin : gParamCheck
    $error("key_rotate_sched: HALF_W must be >= 3 and ROUNDS >= 1");
  end

  function automatic int sumShifts();
    int t = 0;
    for (int r = 0; r < ROUNDS; r++) t += SHIFT_MASK[r] ? 2 : 1;
    return t;
  endfunction

  // Decrypt round 1 equals encrypt round ROUNDS: the seed rotated by the total.
  localparam int unsigned T_MOD = sumShifts() % HALF_W;
  localparam int unsigned S1    = SHIFT_MASK[0] ? 2 : 1;

  function automatic logic [HALF_W-1:0] rotl(logic [HALF_W-1:0] x, int unsigned n);
    // n == 0 is legal: x >> HALF_W yields zero, so the result is x.
    return (x << n) | (x >> (HALF_W - n));
  endfunction

  function automatic logic [HALF_W-1:0] rotr(logic [HALF_W-1:0] x, int unsigned n);
    return (x >> n) | (x << (HALF_W - n));
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state;
  logic              modeQ;
  logic              busyQ, validQ, lastQ;
  logic [HALF_W-1:0] cQ, dQ;
  logic [RW-1:0]     idxQ;

  // Shift for the next round k = idxQ+1:
  //   encrypt s(k)          -> SHIFT_MASK[idxQ]
  //   decrypt s(ROUNDS-k+2) -> SHIFT_MASK[ROUNDS-idxQ]
  logic [ROUNDS-1:0] encSh, decSh;
  int unsigned       stepEnc, stepDec;

  always_comb begin
    encSh   = SHIFT_MASK >> idxQ;
    decSh   = SHIFT_MASK >> (RW'(ROUNDS) - idxQ);
    stepEnc = encSh[0] ? 2 : 1;
    stepDec = decSh[0] ? 2 : 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      modeQ  <= 1'b0;
      busyQ  <= 1'b0;
      validQ <= 1'b0;
      lastQ  <= 1'b0;
      cQ     <= '0;
      dQ     <= '0;
      idxQ   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= EMIT;
            busyQ  <= 1'b1;
            validQ <= 1'b1;
            modeQ  <= bus.mode;
            idxQ   <= RW'(1);
            lastQ  <= (ROUNDS == 1);
            cQ     <= bus.mode ? rotl(bus.cIn, T_MOD) : rotl(bus.cIn, S1);
            dQ     <= bus.mode ? rotl(bus.dIn, T_MOD) : rotl(bus.dIn, S1);
          end
        end
        EMIT: begin
          if (validQ && bus.outReady) begin
            if (lastQ) begin
              // idxQ/cQ/dQ keep the final round's values after completion.
              state  <= IDLE;
              busyQ  <= 1'b0;
              validQ <= 1'b0;
              lastQ  <= 1'b0;
            end else begin
              idxQ  <= idxQ + RW'(1);
              lastQ <= (idxQ == RW'(ROUNDS - 1));
              cQ    <= modeQ ? rotr(cQ, stepDec) : rotl(cQ, stepEnc);
              dQ    <= modeQ ? rotr(dQ, stepDec) : rotl(dQ, stepEnc);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busyQ;
  assign bus.outValid = validQ;
  assign bus.last     = lastQ;
  assign bus.cOut     = cQ;
  assign bus.dOut     = dQ;
  assign bus.roundIdx = idxQ;

endmodule

// File: tb/tb_key_rotate_sched.sv
module tb_key_rotate_sched;
  localparam int          W0  = 28;
  localparam int          R0  = 16;
  localparam int          RW0 = 5;
  localparam logic [15:0] M0  = 16'h7EFC;
  localparam int          W1  = 8;
  localparam int          R1  = 4;
  localparam int          RW1 = 3;
  localparam logic [3:0]  M1  = 4'b0101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_rotate_sched_if #(.HALF_W(W0), .RW(RW0)) bus0();
  key_rotate_sched_if #(.HALF_W(W1), .RW(RW1)) bus1();

  key_rotate_sched #(.HALF_W(W0), .ROUNDS(R0), .SHIFT_MASK(M0), .RW(RW0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  key_rotate_sched #(.HALF_W(W1), .ROUNDS(R1), .SHIFT_MASK(M1), .RW(RW1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: encrypt round k is the seed rotated left by the running sum of
  // shifts; decrypt round k is encrypt round ROUNDS-k+1.
  function automatic logic [27:0] rotM(logic [27:0] x, int n, int w);
    logic [27:0] y = '0;
    for (int i = 0; i < w; i++) y[(i + n) % w] = x[i];
    return y;
  endfunction

  function automatic logic [27:0] expRound(logic [27:0] s, bit m, int k);
    int e   = m ? R0 - k + 1 : k;
    int sum = 0;
    for (int r = 1; r <= e; r++) sum += 1 + int'((M0 >> (r - 1)) & 16'h1);
    return rotM(s, sum % W0, W0);
  endfunction

  typedef struct {
    bit          mode;
    logic [27:0] c, d;
    int          k;
    logic [27:0] expC, expD;
    bit          expLast;
  } vec_t;
  vec_t tbl[6];

  task automatic startSched(bit m, logic [27:0] c, logic [27:0] d);
    @(negedge clk);
    bus0.start = 1'b1; bus0.mode = m; bus0.cIn = c; bus0.dIn = d;
    @(negedge clk);
    // Scramble request inputs once busy; they must have no effect.
    bus0.start = 1'b0; bus0.mode = 1'($urandom);
    bus0.cIn = 28'($urandom); bus0.dIn = 28'($urandom);
  endtask

  task automatic advance(int n);
    bus0.outReady = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic runRandom(bit m, logic [27:0] c, logic [27:0] d);
    int k = 1;
    int guard = 0;
    bit hr;
    startSched(m, c, d);
    while (k <= R0 && guard < 400) begin
      guard++;
      check("rnd valid", bus0.outValid, 1);
      check("rnd busy", bus0.busy, 1);
      check("rnd idx", bus0.roundIdx, k);
      check("rnd c", bus0.cOut, expRound(c, m, k));
      check("rnd d", bus0.dOut, expRound(d, m, k));
      check("rnd last", bus0.last, (k == R0));
      hr = ($urandom_range(0, 3) != 0);
      bus0.outReady = hr;
      bus0.start = ($urandom_range(0, 5) == 0);
      bus0.cIn = 28'($urandom); bus0.dIn = 28'($urandom); bus0.mode = 1'($urandom);
      @(negedge clk);
      if (hr) k++;
    end
    if (guard >= 400) check("rnd timeout", guard, 0);
    bus0.start = 1'b0;
    bus0.outReady = 1'($urandom);
    check("done valid", bus0.outValid, 0);
    check("done busy", bus0.busy, 0);
    check("done last", bus0.last, 0);
    check("done idx", bus0.roundIdx, R0);
    check("done c", bus0.cOut, expRound(c, m, R0));
    @(negedge clk);
    check("idle stays", bus0.busy, 0);
  endtask

  logic [7:0] vC[4];
  logic [7:0] vD[4];
  logic [27:0] sa, sb;

  initial begin
    bus0.start = 0; bus0.mode = 0; bus0.cIn = '0; bus0.dIn = '0; bus0.outReady = 0;
    bus1.start = 0; bus1.mode = 0; bus1.cIn = '0; bus1.dIn = '0; bus1.outReady = 0;
    tbl[0] = '{0, 28'hF0CCAAF, 28'h556678F, 1,  28'hE19955F, 28'hAACCF1E, 0};
    tbl[1] = '{0, 28'hF0CCAAF, 28'h556678F, 2,  28'hC332ABF, 28'h5599E3D, 0};
    tbl[2] = '{0, 28'hF0CCAAF, 28'h556678F, 3,  28'h0CCAAFF, 28'h56678F5, 0};
    tbl[3] = '{0, 28'hF0CCAAF, 28'h556678F, 16, 28'hF0CCAAF, 28'h556678F, 1};
    tbl[4] = '{1, 28'hF0CCAAF, 28'h556678F, 1,  28'hF0CCAAF, 28'h556678F, 0};
    tbl[5] = '{1, 28'hF0CCAAF, 28'h556678F, 16, 28'hE19955F, 28'hAACCF1E, 1};
    vC = '{8'h06, 8'h0C, 8'h30, 8'h60};
    vD = '{8'h04, 8'h08, 8'h20, 8'h40};

    // Reset state
    @(negedge clk);
    check("rst busy", bus0.busy, 0);
    check("rst valid", bus0.outValid, 0);
    check("rst last", bus0.last, 0);
    check("rst c", bus0.cOut, 0);
    check("rst d", bus0.dOut, 0);
    check("rst idx", bus0.roundIdx, 0);
    check("rst busy1", bus1.busy, 0);
    reset = 1'b0;

    // Known-answer table
    for (int i = 0; i < 6; i++) begin
      startSched(tbl[i].mode, tbl[i].c, tbl[i].d);
      advance(tbl[i].k - 1);
      check("tbl idx", bus0.roundIdx, tbl[i].k);
      check("tbl c", bus0.cOut, tbl[i].expC);
      check("tbl d", bus0.dOut, tbl[i].expD);
      check("tbl last", bus0.last, tbl[i].expLast);
      check("tbl busy", bus0.busy, 1);
      advance(R0 - tbl[i].k + 1);
      check("tbl end busy", bus0.busy, 0);
      check("tbl end valid", bus0.outValid, 0);
    end

    // Backpressure at round 4
    sa = 28'h1234567;
    startSched(0, sa, ~sa);
    advance(3);
    bus0.outReady = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp idx", bus0.roundIdx, 4);
      check("bp valid", bus0.outValid, 1);
      check("bp c", bus0.cOut, expRound(sa, 0, 4));
      check("bp d", bus0.dOut, expRound(~sa, 0, 4));
      check("bp last", bus0.last, 0);
    end
    advance(1);
    check("bp resume idx", bus0.roundIdx, 5);
    check("bp resume c", bus0.cOut, expRound(sa, 0, 5));
    advance(R0 - 5 + 1);

    // Start pulsed mid-schedule at round 7
    startSched(0, sa, sa);
    advance(6);
    bus0.start = 1'b1; bus0.cIn = 28'hABCDEF0; bus0.mode = 1'b1;
    advance(1);
    bus0.start = 1'b0;
    check("ign idx", bus0.roundIdx, 8);
    check("ign c", bus0.cOut, expRound(sa, 0, 8));
    advance(R0 - 8 + 1);

    // Async reset at round 9
    sb = 28'h0F0F0F1;
    startSched(0, sa, sa);
    advance(8);
    check("pre-rst idx", bus0.roundIdx, 9);
    #2 reset = 1'b1;
    #1;
    check("arst busy", bus0.busy, 0);
    check("arst valid", bus0.outValid, 0);
    check("arst last", bus0.last, 0);
    @(negedge clk);
    reset = 1'b0;
    startSched(1, sb, ~sb);
    check("post-rst idx", bus0.roundIdx, 1);
    check("post-rst c", bus0.cOut, expRound(sb, 1, 1));
    check("post-rst d", bus0.dOut, expRound(~sb, 1, 1));
    advance(R0);

    // Randomized schedules
    for (int i = 0; i < 8; i++)
      runRandom(1'($urandom), 28'($urandom), 28'($urandom));

    // Small parameter variant
    @(negedge clk);
    bus1.start = 1'b1; bus1.mode = 1'b0; bus1.cIn = 8'h81; bus1.dIn = 8'h01;
    bus1.outReady = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int k = 0; k < R1; k++) begin
      check("var c", bus1.cOut, vC[k]);
      check("var d", bus1.dOut, vD[k]);
      check("var idx", bus1.roundIdx, k + 1);
      check("var last", bus1.last, (k == R1 - 1));
      @(negedge clk);
    end
    check("var busy", bus1.busy, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
